wb_sram_slave: RTL and testbench

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

---
 rtl/wb_sram_slave.sv | 84 ++++++++
 tb/tb_wb_sram_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone classic single-access slave over an internal 2^DEPTH_LOG2 x 32 RAM
// Optional WB_SRAM_WAIT_STATE_EN adds a WAIT state (one extra cycle of latency, abort on strobe drop).
`timescale 1ns/1ps
module wb_sram_slave #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  req;
  logic                  enter_ack;
  logic                  ram_wr;
  logic                  unused_adr;

  assign idx        = wb_adr_i[DEPTH_LOG2+1:2];
  assign req        = wb_cyc_i & wb_stb_i;
  assign unused_adr = ^{wb_adr_i[31:DEPTH_LOG2+2], wb_adr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef WB_SRAM_WAIT_STATE_EN
      IDLE:    if (req) state_next = WAIT;
      WAIT:    state_next = req ? ACK : IDLE;
`else
      IDLE:    if (req) state_next = ACK;
`endif
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All bus sampling happens on the edge that moves the FSM into ACK.
  always_comb begin
    enter_ack = (state_next == ACK);
    ram_wr    = enter_ack & wb_we_i & ~rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      wb_ack_o <= enter_ack;
      if (enter_ack && !wb_we_i) wb_dat_o <= mem[idx];
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - self-checking bench for wb_sram_slave (vector table, corner sequences, random vs model)
`timescale 1ns/1ps
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = 32'h0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  always #5 clk = ~clk;

  wb_sram_slave #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

`ifdef WB_SRAM_WAIT_STATE_EN
  localparam int LAT = 2;
  localparam int HELD_ACKS = 2;
`else
  localparam int LAT = 1;
  localparam int HELD_ACKS = 3;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] model [1024];
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (int'(a) >>> 2) & 1023;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wb_ack_o && lat < 10);
    rd = wb_dat_o;
    chk("ack_latency", 32'(lat), 32'(LAT));
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", 32'(wb_ack_o), 32'h0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int acks, adjacent;
    logic prev;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h11223344, 4'h5, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDE22BE44};
    vecs[4] = '{1'b1, 32'h0000_0014, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_1014, 32'h0,        4'hF, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDE22BE44};
    vecs[7] = '{1'b1, 32'h0000_0FFC, 32'h01234567, 4'hF, 32'h0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        4'h2, 32'h01234567};

    @(negedge clk);
    chk("reset_ack", 32'(wb_ack_o), 32'h0);
    chk("reset_dat", wb_dat_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      xact(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
      if (vecs[i].we) begin
        chk("vec_wr_keeps_dat", rd, last_rd);
        model_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      end else begin
        chk("vec_rd_data", rd, vecs[i].exp);
        last_rd = rd;
      end
    end

    // Held strobe: acks must be separated by at least one low cycle.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h0000_0014; wb_sel_i = 4'hF;
    acks = 0; adjacent = 0; prev = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        acks++;
        chk("held_rd_data", wb_dat_o, 32'hCAFEF00D);
      end
      if (wb_ack_o && prev) adjacent++;
      prev = wb_ack_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk("held_ack_count", 32'(acks), 32'(HELD_ACKS));
    chk("held_ack_adjacent", 32'(adjacent), 32'h0);
    last_rd = 32'hCAFEF00D;

    // Asynchronous reset in the middle of a read's ACK cycle.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h0000_0010; wb_sel_i = 4'hF;
    for (int c = 0; c < 10 && !wb_ack_o; c++) @(negedge clk);
    chk("rst_pre_ack", 32'(wb_ack_o), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_async_dat", wb_dat_o, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1 rst = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    chk("rst_no_ack", 32'(wb_ack_o), 32'h0);
    xact(1'b0, 32'h0000_0014, 32'h0, 4'hF, rd);
    chk("rst_then_read", rd, model[widx(32'h14)]);
    last_rd = rd;

`ifdef WB_SRAM_WAIT_STATE_EN
    // Strobe dropped during WAIT must abort the write.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h0000_0010; wb_dat_i = 32'hFFFFFFFF; wb_sel_i = 4'hF;
    @(negedge clk);
    wb_stb_i = 1'b0;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0;
    chk("abort_no_ack", 32'(acks), 32'h0);
    xact(1'b0, 32'h0000_0010, 32'h0, 4'hF, rd);
    chk("abort_prior_value", rd, model[widx(32'h10)]);
    last_rd = rd;
`endif

    // Random traffic over a small pool of words reached through aliased addresses.
    for (int p = 0; p < 16; p++) begin
      logic [31:0] a, d;
      a = 32'((p * 67 + 5) % 1024) << 2;
      d = $urandom;
      xact(1'b1, a, d, 4'hF, rd);
      model_write(a, d, 4'hF);
    end
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      bit          we;
      int unsigned p;
      p  = $urandom_range(0, 15);
      a  = ($urandom & 32'hFFFF_F000) | (32'((p * 67 + 5) % 1024) << 2) | ($urandom & 32'h3);
      d  = $urandom;
      s  = 4'($urandom);
      we = 1'($urandom);
      xact(we, a, d, s, rd);
      if (we) begin
        chk("rand_wr_keeps_dat", rd, last_rd);
        model_write(a, d, s);
      end else begin
        chk("rand_rd_data", rd, model[widx(a)]);
        last_rd = rd;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
